// File: rtl/vip_axi4_rd_responder_if.sv
// AXI4 read-address and read-data channel bundle for vip_axi4_rd_responder.
// slave = responder side, master = requester side.
interface vip_axi4_rd_responder_if #(
  parameter int unsigned ID_WIDTH_P   = 4,
  parameter int unsigned ADDR_WIDTH_P = 32,
  parameter int unsigned DATA_WIDTH_P = 64,
  parameter int unsigned USER_WIDTH_P = 1
);
  logic [ID_WIDTH_P-1:0]   arid;
  logic [ADDR_WIDTH_P-1:0] araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [USER_WIDTH_P-1:0] aruser;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH_P-1:0]   rid;
  logic [DATA_WIDTH_P-1:0] rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [USER_WIDTH_P-1:0] ruser;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, aruser, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, ruser, rvalid
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, aruser, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, ruser, rvalid
  );
endinterface

// File: rtl/vip_axi4_rd_responder.sv
// AXI4 read responder: one AR at a time, each beat fetched from a
// synchronous-read memory port (data valid one cycle after mem_rd).
// Illegal requests return len+1 SLVERR beats without touching memory.
// Optional macro VIP_AXI4_RD_RESPONDER_DELAY_EN adds cfg_delay idle cycles
// between data capture and rvalid on every OKAY beat.
module vip_axi4_rd_responder #(
  parameter int unsigned ID_WIDTH_P   = 4,
  parameter int unsigned ADDR_WIDTH_P = 32,
  parameter int unsigned DATA_WIDTH_P = 64,
  parameter int unsigned USER_WIDTH_P = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  vip_axi4_rd_responder_if.slave  axi,
  output logic                    mem_rd,
  output logic [ADDR_WIDTH_P-1:0] mem_addr,
  input  logic [DATA_WIDTH_P-1:0] mem_rdata,
  input  logic [3:0]              cfg_delay
);

`ifdef VIP_AXI4_RD_RESPONDER_DELAY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_CAPTURE, ST_RESP, ST_DELAY} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_CAPTURE, ST_RESP} state_e;
`endif

  typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RSVD} burst_e;

  localparam logic [ADDR_WIDTH_P-1:0] ONE_LP      = ADDR_WIDTH_P'(1);
  localparam logic [ADDR_WIDTH_P-1:0] DBYTES_LP   = ADDR_WIDTH_P'(DATA_WIDTH_P / 8);
  localparam int unsigned             MAX_SIZE_LP = $clog2(DATA_WIDTH_P / 8);
  localparam logic [1:0]              RESP_OKAY   = 2'b00;
  localparam logic [1:0]              RESP_SLVERR = 2'b10;

  state_e                  state_q, state_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic                    rlast_q, rlast_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [ID_WIDTH_P-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH_P-1:0] rdata_q, rdata_d;
  logic [USER_WIDTH_P-1:0] ruser_q, ruser_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH_P-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH_P-1:0] addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  burst_e                  burst_q, burst_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic                    err_q, err_d;
`ifdef VIP_AXI4_RD_RESPONDER_DELAY_EN
  logic [3:0]              delay_cnt_q, delay_cnt_d;
`else
  logic                    unused_cfg_delay;
  assign unused_cfg_delay = ^cfg_delay;
`endif

  logic                    req_illegal;
  logic [ADDR_WIDTH_P-1:0] nxt_addr;

  function automatic logic [ADDR_WIDTH_P-1:0] beat_bytes(input logic [2:0] size);
    return ONE_LP << size;
  endfunction

  function automatic logic [ADDR_WIDTH_P-1:0] align_down(
    input logic [ADDR_WIDTH_P-1:0] a, input logic [ADDR_WIDTH_P-1:0] bytes);
    return a & ~(bytes - ONE_LP);
  endfunction

  // Address of the beat following 'a' for the captured burst type.
  function automatic logic [ADDR_WIDTH_P-1:0] next_beat_addr(
    input logic [ADDR_WIDTH_P-1:0] a, input logic [2:0] size,
    input logic [7:0] len, input burst_e burst);
    logic [ADDR_WIDTH_P-1:0] bytes, total, lo, nxt;
    bytes = beat_bytes(size);
    total = bytes * (ADDR_WIDTH_P'(len) + ONE_LP);
    lo    = a & ~(total - ONE_LP);
    nxt   = a + bytes;
    case (burst)
      BURST_INCR: nxt = align_down(a, bytes) + bytes;
      BURST_WRAP: if (nxt == lo + total) nxt = lo;
      default:    nxt = a;
    endcase
    return nxt;
  endfunction

  function automatic logic is_illegal(
    input burst_e burst, input logic [2:0] size, input logic [7:0] len,
    input logic [11:0] page_off);
    logic [31:0] off, span;
    logic        bad;
    off  = 32'(page_off) & ~((32'd1 << size) - 32'd1);
    span = (32'(len) + 32'd1) << size;
    bad  = 1'b0;
    if (burst == BURST_RSVD) bad = 1'b1;
    if (32'(size) > MAX_SIZE_LP) bad = 1'b1;
    if (burst == BURST_INCR && (off + span) > 32'd4096) bad = 1'b1;
    if (burst == BURST_WRAP &&
        !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) bad = 1'b1;
    if (burst == BURST_FIXED && len > 8'd15) bad = 1'b1;
    return bad;
  endfunction

  assign req_illegal = is_illegal(burst_e'(axi.arburst), axi.arsize, axi.arlen,
                                  axi.araddr[11:0]);
  assign nxt_addr    = next_beat_addr(addr_q, size_q, len_q, burst_q);

  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rresp   = rresp_q;
  assign axi.rid     = rid_q;
  assign axi.rdata   = rdata_q;
  assign axi.ruser   = ruser_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;

  // State and registered-output update; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rresp_q     <= '0;
      rid_q       <= '0;
      rdata_q     <= '0;
      ruser_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= BURST_FIXED;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
`ifdef VIP_AXI4_RD_RESPONDER_DELAY_EN
      delay_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rresp_q     <= rresp_d;
      rid_q       <= rid_d;
      rdata_q     <= rdata_d;
      ruser_q     <= ruser_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
`ifdef VIP_AXI4_RD_RESPONDER_DELAY_EN
      delay_cnt_q <= delay_cnt_d;
`endif
    end
  end

  // Next-state and next-output logic. mem_rd is raised on entry to FETCH so
  // the strobe is registered yet lines up with the FETCH cycle itself.
  always_comb begin
    state_d     = state_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rresp_d     = rresp_q;
    rid_d       = rid_q;
    rdata_d     = rdata_q;
    ruser_d     = ruser_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
`ifdef VIP_AXI4_RD_RESPONDER_DELAY_EN
    delay_cnt_d = delay_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        if (axi.arvalid && arready_q) begin
          arready_d  = 1'b0;
          rid_d      = axi.arid;
          ruser_d    = axi.aruser;
          addr_d     = axi.araddr;
          len_d      = axi.arlen;
          size_d     = axi.arsize;
          burst_d    = burst_e'(axi.arburst);
          beat_cnt_d = '0;
          err_d      = req_illegal;
          if (req_illegal) begin
            state_d  = ST_RESP;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            rlast_d  = (axi.arlen == 8'd0);
          end else begin
            state_d    = ST_FETCH;
            mem_rd_d   = 1'b1;
            mem_addr_d = align_down(axi.araddr, DBYTES_LP);
          end
        end
      end

      ST_FETCH: begin
        if (err_q) begin
          state_d  = ST_RESP;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          rlast_d  = (beat_cnt_q == len_q);
        end else begin
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        rdata_d = mem_rdata;
        rresp_d = RESP_OKAY;
        rlast_d = (beat_cnt_q == len_q);
`ifdef VIP_AXI4_RD_RESPONDER_DELAY_EN
        if (cfg_delay != 4'd0) begin
          delay_cnt_d = cfg_delay;
          state_d     = ST_DELAY;
        end else begin
          rvalid_d = 1'b1;
          state_d  = ST_RESP;
        end
`else
        rvalid_d = 1'b1;
        state_d  = ST_RESP;
`endif
      end

`ifdef VIP_AXI4_RD_RESPONDER_DELAY_EN
      ST_DELAY: begin
        if (delay_cnt_q <= 4'd1) begin
          rvalid_d = 1'b1;
          state_d  = ST_RESP;
        end else begin
          delay_cnt_d = delay_cnt_q - 4'd1;
        end
      end
`endif

      ST_RESP: begin
        if (rvalid_q && axi.rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            state_d   = ST_IDLE;
            arready_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            addr_d     = nxt_addr;
            state_d    = ST_FETCH;
            if (!err_q) begin
              mem_rd_d   = 1'b1;
              mem_addr_d = align_down(nxt_addr, DBYTES_LP);
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vip_axi4_rd_responder.sv
// Self-checking bench for vip_axi4_rd_responder: directed bursts from the
// test plan followed by randomized bursts, all compared against a
// behavioural model of AXI4 address generation and legality rules.
module tb_vip_axi4_rd_responder;
  localparam int unsigned IDW = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 64;
  localparam int unsigned UW  = 1;
`ifdef VIP_AXI4_RD_RESPONDER_DELAY_EN
  localparam int unsigned DLY = 5;
`else
  localparam int unsigned DLY = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [3:0]    cfg_delay;

  int            checks = 0;
  int            errors = 0;
  int            mem_rd_cnt = 0;
  logic [31:0]   rd_q[$];
  logic [31:0]   seed_hi, seed_lo;

  vip_axi4_rd_responder_if #(.ID_WIDTH_P(IDW), .ADDR_WIDTH_P(AW),
                             .DATA_WIDTH_P(DW), .USER_WIDTH_P(UW)) axi_if ();

  vip_axi4_rd_responder #(.ID_WIDTH_P(IDW), .ADDR_WIDTH_P(AW),
                          .DATA_WIDTH_P(DW), .USER_WIDTH_P(UW)) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (axi_if),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .cfg_delay (cfg_delay)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word(input logic [31:0] a);
    return {a ^ seed_hi, (a * 32'h9E3779B1) ^ seed_lo};
  endfunction

  // AXI4 legality rules in plain arithmetic.
  function automatic bit model_illegal(input logic [31:0] start, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
    longint unsigned bytes, first, last;
    bytes = 64'd1 << size;
    if (burst == 2'd3) return 1'b1;
    if (bytes * 8 > DW) return 1'b1;
    if (burst == 2'd1) begin
      first = longint'(start) & ~(bytes - 1);
      last  = first + (longint'(len) + 1) * bytes - 1;
      if ((first / 4096) != (last / 4096)) return 1'b1;
    end
    if (burst == 2'd2 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) return 1'b1;
    if (burst == 2'd0 && len > 8'd15) return 1'b1;
    return 1'b0;
  endfunction

  // Byte address of beat n, computed directly rather than by stepping.
  function automatic logic [31:0] model_addr(input logic [31:0] start, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int n);
    longint unsigned bytes, total, lo, s;
    bytes = 64'd1 << size;
    s     = longint'(start);
    case (burst)
      2'd1: begin
        if (n == 0) return start;
        return 32'((s & ~(bytes - 1)) + longint'(n) * bytes);
      end
      2'd2: begin
        total = bytes * (longint'(len) + 1);
        lo    = s - (s % total);
        return 32'(lo + ((s - lo) + longint'(n) * bytes) % total);
      end
      default: return start;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synchronous-read memory: data for a strobed address appears on the
  // following cycle; otherwise the bus carries noise.
  initial begin
    logic        r;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      r = mem_rd;
      a = mem_addr;
      if (r === 1'b1) begin
        mem_rd_cnt++;
        rd_q.push_back(a);
      end
      @(posedge clk);
      #1;
      mem_rdata = (r === 1'b1) ? word(a) : {$urandom, $urandom};
    end
  end

  task automatic check_beat(input int b, input logic [7:0] len, input bit err,
                            input logic [3:0] id, input logic user, input logic [63:0] exp_data);
    check("rvalid",      axi_if.rvalid, 1);
    check("arready_busy", axi_if.arready, 0);
    check("rid",         axi_if.rid, id);
    check("rdata",       axi_if.rdata, exp_data);
    check("rresp",       axi_if.rresp, err ? 2 : 0);
    check("rlast",       axi_if.rlast, (b == int'(len)) ? 1 : 0);
    check("ruser",       axi_if.ruser, user);
    check("mem_rd_cnt",  mem_rd_cnt, err ? 0 : b + 1);
  endtask

  task automatic reset_abort();
    rst = 1'b1;
    #1;
    check("abort_rvalid",  axi_if.rvalid, 0);
    check("abort_arready", axi_if.arready, 0);
    check("abort_rlast",   axi_if.rlast, 0);
    check("abort_rdata",   axi_if.rdata, 0);
    check("abort_mem_rd",  mem_rd, 0);
    tick();
    tick();
    rst = 1'b0;
    check("abort_arready_release", axi_if.arready, 0);
    tick();
    check("abort_arready_up", axi_if.arready, 1);
    repeat (5) begin
      tick();
      check("abort_no_beat",   axi_if.rvalid, 0);
      check("abort_no_mem_rd", mem_rd, 0);
    end
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [31:0] start, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic user,
                           input int stall_beat, input int stall_cyc, input int abort_beat);
    bit          err;
    int          n, lat, waits;
    int unsigned exp_gap;
    string       tg;
    logic [31:0] exp_mem[$];
    logic [63:0] exp_data;
    logic [63:0] got;

    err = model_illegal(start, len, size, burst);
    exp_mem.delete();
    if (!err)
      for (int b = 0; b <= int'(len); b++)
        exp_mem.push_back(model_addr(start, len, size, burst, b) & ~32'h7);
    rd_q.delete();
    mem_rd_cnt = 0;

    axi_if.arid    = id;
    axi_if.araddr  = start;
    axi_if.arlen   = len;
    axi_if.arsize  = size;
    axi_if.arburst = burst;
    axi_if.aruser  = user;
    axi_if.arvalid = 1'b1;
    n = 0;
    while (axi_if.arready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (axi_if.arready !== 1'b1) begin
      check("arready_timeout", axi_if.arready, 1);
      axi_if.arvalid = 1'b0;
      return;
    end
    tick();
    axi_if.arvalid = 1'b0;
    axi_if.araddr  = $urandom;
    axi_if.arid    = 4'($urandom);

    for (int b = 0; b <= int'(len); b++) begin
      lat = 1;
      while (axi_if.rvalid !== 1'b1 && lat < 40) begin
        tick();
        lat++;
      end
      if (axi_if.rvalid !== 1'b1) begin
        check("rvalid_timeout", axi_if.rvalid, 1);
        return;
      end
      exp_gap = err ? ((b == 0) ? 1 : 2) : 3 + DLY;
      tg = (b == 0) ? "ar_to_rvalid" : "beat_gap";
      check(tg, lat, exp_gap);
      if (b == abort_beat) begin
        reset_abort();
        return;
      end
      exp_data = err ? 64'd0 : word(model_addr(start, len, size, burst, b) & ~32'h7);
      check_beat(b, len, err, id, user, exp_data);
      waits = (b == stall_beat) ? stall_cyc : int'($urandom_range(0, 2));
      if (waits > 0) begin
        axi_if.rready = 1'b0;
        repeat (waits) begin
          tick();
          check_beat(b, len, err, id, user, exp_data);
        end
        axi_if.rready = 1'b1;
      end
      tick();
    end
    check("arready_after_last", axi_if.arready, 1);
    check("mem_rd_total", rd_q.size(), exp_mem.size());
    for (int i = 0; i < exp_mem.size(); i++) begin
      got = (i < rd_q.size()) ? 64'(rd_q[i]) : 64'hx;
      check("mem_addr", got, exp_mem[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  bt;
    logic [2:0]  sz;
    logic [7:0]  ln;
    logic [31:0] ad;
    int          r;

    seed_hi = $urandom;
    seed_lo = $urandom;
    rst = 1'b1;
    cfg_delay = 4'd5;
    mem_rdata = '0;
    axi_if.arvalid = 1'b0;
    axi_if.arid    = '0;
    axi_if.araddr  = '0;
    axi_if.arlen   = '0;
    axi_if.arsize  = '0;
    axi_if.arburst = '0;
    axi_if.aruser  = '0;
    axi_if.rready  = 1'b0;
    repeat (3) tick();

    check("rst_arready",  axi_if.arready, 0);
    check("rst_rvalid",   axi_if.rvalid, 0);
    check("rst_rlast",    axi_if.rlast, 0);
    check("rst_rresp",    axi_if.rresp, 0);
    check("rst_rid",      axi_if.rid, 0);
    check("rst_rdata",    axi_if.rdata, 0);
    check("rst_ruser",    axi_if.ruser, 0);
    check("rst_mem_rd",   mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    check("release_arready", axi_if.arready, 0);
    tick();
    check("arready_after_release", axi_if.arready, 1);
    axi_if.rready = 1'b1;

    // INCR with unaligned narrow start
    run_burst(4'h5, 32'h1004, 8'd3, 3'd2, 2'd1, 1'b1, -1, 0, -1);
    // WRAP across the wrap boundary
    run_burst(4'hA, 32'h38, 8'd3, 3'd3, 2'd2, 1'b0, -1, 0, -1);
    // rready low for 10 cycles on beat 1
    run_burst(4'h3, 32'h200, 8'd3, 3'd3, 2'd1, 1'b1, 1, 10, -1);
    // INCR crossing 4 KB
    run_burst(4'h7, 32'hFF8, 8'd3, 3'd3, 2'd1, 1'b0, -1, 0, -1);
    // other illegal forms
    run_burst(4'h1, 32'h100, 8'd1, 3'd2, 2'd3, 1'b1, -1, 0, -1);
    run_burst(4'h2, 32'h100, 8'd0, 3'd4, 2'd1, 1'b0, -1, 0, -1);
    run_burst(4'h4, 32'h100, 8'd2, 3'd2, 2'd2, 1'b1, -1, 0, -1);
    run_burst(4'h6, 32'h100, 8'd16, 3'd2, 2'd0, 1'b0, -1, 0, -1);
    // FIXED and single-beat latency
    run_burst(4'h9, 32'h123, 8'd4, 3'd2, 2'd0, 1'b1, -1, 0, -1);
    run_burst(4'hC, 32'h440, 8'd0, 3'd3, 2'd1, 1'b0, -1, 0, -1);
    // reset during beat 2 of an 8-beat burst, then a fresh 8-beat burst
    run_burst(4'hB, 32'h800, 8'd7, 3'd3, 2'd1, 1'b1, -1, 0, 2);
    run_burst(4'hD, 32'h800, 8'd7, 3'd3, 2'd1, 1'b1, -1, 0, -1);

    for (int k = 0; k < 16; k++) begin
      r  = int'($urandom_range(0, 9));
      bt = (r < 3) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      sz = 3'($urandom_range(0, 4));
      ad = $urandom_range(0, 32'hFFFF);
      case (bt)
        2'd0:    ln = 8'($urandom_range(0, 17));
        2'd2: begin
          r  = int'($urandom_range(0, 4));
          ln = (r == 0) ? 8'd1 : (r == 1) ? 8'd3 : (r == 2) ? 8'd7 : (r == 3) ? 8'd15 : 8'd2;
          ad = ad & ~((32'd1 << sz) - 32'd1);
        end
        default: ln = 8'($urandom_range(0, 15));
      endcase
      run_burst(4'($urandom), ad, ln, sz, bt, 1'($urandom), -1, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vip_axi4_rd_responder.md
Name: vip_axi4_rd_responder

Overview:
- AXI4 read-channel subordinate (responder) for VIP benches.
- Accepts one AR request at a time and fetches each beat from a synchronous-read memory port.
- Returns arlen+1 R beats with correct RID, RLAST and RRESP.
- Obeys every AR/R handshake rule the team's AXI4 read checkers enforce, so it can be bound alongside them.

Parameters:
ID_WIDTH_P, 4, width of arid/rid
ADDR_WIDTH_P, 32, width of araddr and mem_addr
DATA_WIDTH_P, 64, width of rdata and mem_rdata in bits (8..1024, power of 2)
USER_WIDTH_P, 1, width of aruser/ruser

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
arid  in  ID_WIDTH_P  request ID
araddr  in  ADDR_WIDTH_P  start byte address
arlen  in  8  beats minus one
arsize  in  3  log2 bytes per beat
arburst  in  2  FIXED=0, INCR=1, WRAP=2
aruser  in  USER_WIDTH_P  user sideband, echoed on every beat
arvalid  in  1  request valid
arready  out  1  request accept
rid  out  ID_WIDTH_P  = captured arid
rdata  out  DATA_WIDTH_P  beat data
rresp  out  2  OKAY=0, SLVERR=2
rlast  out  1  final beat
ruser  out  USER_WIDTH_P  = captured aruser
rvalid  out  1  beat valid
rready  in  1  beat accept
mem_rd  out  1  one-cycle read strobe
mem_addr  out  ADDR_WIDTH_P  beat address, aligned down to DATA_WIDTH_P/8
mem_rdata  in  DATA_WIDTH_P  read data, valid exactly 1 cycle after mem_rd
cfg_delay  in  4  extra idle cycles before each rvalid (used only with optional feature)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values (all outputs registered): arready=0, rvalid=0, rlast=0, mem_rd=0, rresp=0, rid/rdata/ruser/mem_addr=0. State returns to IDLE.
- First cycle after rst deasserts: arready rises to 1.
- FSM states: IDLE, FETCH, CAPTURE, RESP.
- IDLE:
  - arready=1.
  - On arvalid&&arready, capture all AR fields into registers, set beat_cnt=0, drop arready next cycle.
  - Go to FETCH, or to RESP with error data if the request is illegal.
- FETCH: mem_rd=1 and mem_addr=beat address for one cycle, then go to CAPTURE.
- CAPTURE:
  - Register mem_rdata into rdata.
  - rlast=(beat_cnt==len), rresp=OKAY, rvalid=1 next cycle.
  - Go to RESP.
- RESP:
  - rvalid held; rid, rdata, rresp, rlast, ruser held stable until rready.
  - On rvalid&&rready: if rlast, go to IDLE with arready=1 next cycle; else beat_cnt+1, advance address, go to FETCH.
  - rvalid deasserts in the accept cycle+1 unless the next beat is ready; no back-to-back beats are required.
- Throughput: minimum 3 cycles per beat. AR-accept to first rvalid is 3 cycles.
- Address arithmetic (width ADDR_WIDTH_P, bytes=1<<size):
  - FIXED: every beat uses the start address.
  - INCR: beat0 = start; beat n = (start aligned down to bytes) + n*bytes.
  - WRAP: total=bytes*(len+1), lo=start & ~(total-1). Next address = addr+bytes; if it equals lo+total it becomes lo.
- Illegal requests (no mem_rd issued): arburst==3, bytes*8 > DATA_WIDTH_P, INCR crossing 4 KB, WRAP with len not in {1,3,7,15}, FIXED with len>15.
  - Still returns exactly len+1 beats, each with rresp=SLVERR (2'b10) and rdata=0.
  - One beat per 2 cycles (RESP with rvalid, then one idle cycle).
- Simultaneous events:
  - arvalid is ignored outside IDLE; arready is 0 there.
  - rready without rvalid has no effect.
- rst asserted mid-burst: immediate abort, all outputs to reset values, no further beats after release.

Optional Feature:
- Macro: VIP_AXI4_RD_RESPONDER_DELAY_EN.
- Defined: a DELAY state is inserted between CAPTURE and rvalid assertion. It counts cfg_delay cycles (sampled at CAPTURE; 0 = no delay). rdata is held internally; rvalid stays 0 during the count.
- Not defined: cfg_delay is ignored and the latency is exactly as above.

Test Plan:
- INCR, araddr=0x1004, arlen=3, arsize=2 (4 B), DATA_WIDTH_P=64 -> mem_addr 0x1000,0x1008,0x1008,0x1010 (beat addresses 0x1004/8/C/10). 4 OKAY beats, rlast only on beat 3, rid=arid.
- WRAP, araddr=0x38, arlen=3, arsize=3 -> beat addresses 0x38,0x20,0x28,0x30. rlast on 4th beat.
- rready held low 10 cycles during beat 1 -> rvalid and rdata/rid/rlast/rresp stable all 10 cycles. No mem_rd issued during the stall.
- INCR, araddr=0xFF8, arlen=3, arsize=3 (crosses 4 KB) -> 4 beats, rresp=2'b10, rdata=0, mem_rd never asserted. arready back to 1 after the last accept.
- rst pulsed during beat 2 of an arlen=7 burst -> rvalid=0 and arready=0 asynchronously. arready=1 one cycle after release, and a fresh AR returns all 8 beats.
- With VIP_AXI4_RD_RESPONDER_DELAY_EN, cfg_delay=5, arlen=0 -> rvalid rises 8 cycles after AR accept. Without the macro, same stimulus -> 3 cycles.
